// File: rtl/ps2_scancode.sv
// rtl/ps2_scancode.sv - PS/2 device-to-host frame receiver and scancode event decoder
// Strips E0/F0/E1 prefixes and presents one strobed key event per make/break code.
module ps2_scancode #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2,
  output logic        error
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [0:0]    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [8:0]    sr_q, sr_d;
  logic [TW-1:0] to_q, to_d;
  logic          rx_done_q, rx_done_d, rx_ok_q, rx_ok_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic          strobe_q, strobe_d, error_q, error_d;
  logic [9:0]    code_q, code_d;
  logic          fall, to_err;

  always_comb begin
    filt_d    = filt_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    to_d      = to_q;
    rx_done_d = 1'b0;
    rx_ok_d   = 1'b0;
    ext_d     = ext_q;
    brk_d     = brk_q;
    skip_d    = skip_q;
    strobe_d  = 1'b0;
    code_d    = code_q;
    to_err    = 1'b0;

    // The filtered level only flips after FILTER consecutive cycles of disagreement.
    fall = filt_q & ~clk_s2_q & (fcnt_q == FW'(FILTER - 1));
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER - 1)) begin
      fcnt_d = '0;
      filt_d = clk_s2_q;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end

    case (state_q)
      IDLE: begin
        to_d = '0;
        if (fall && !dat_s2_q) begin
          state_d  = RECV;
          bitcnt_d = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          to_d = '0;
          if (bitcnt_q == 4'd10) begin
            state_d   = IDLE;
            bitcnt_d  = 4'd0;
            rx_done_d = 1'b1;
            rx_ok_d   = (^sr_q) & dat_s2_q;
          end else begin
            sr_d     = {dat_s2_q, sr_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (to_q == TW'(TIMEOUT)) begin
          state_d  = IDLE;
          bitcnt_d = 4'd0;
          to_d     = '0;
          to_err   = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    error_d = to_err | (rx_done_q & ~rx_ok_q);

    // sr_q holds the completed byte in the cycle after the stop bit.
    if (rx_done_q) begin
      if (!rx_ok_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (sr_q[7:0])
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!(ext_q && (sr_q[7:0] == 8'h12 || sr_q[7:0] == 8'h59))) begin
              strobe_d = 1'b1;
              code_d   = {brk_q, ext_q, sr_q[7:0]};
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= IDLE;
      bitcnt_q  <= 4'd0;
      sr_q      <= '0;
      to_q      <= '0;
      rx_done_q <= 1'b0;
      rx_ok_q   <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      skip_q    <= 3'd0;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      to_q      <= to_d;
      rx_done_q <= rx_done_d;
      rx_ok_q   <= rx_ok_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      skip_q    <= skip_d;
      strobe_q  <= strobe_d;
      error_q   <= error_d;
      code_q    <= code_d;
    end
  end

  assign ps2   = {strobe_q, code_q};
  assign error = error_q;

endmodule

// File: tb/tb_ps2_scancode.sv
// tb/tb_ps2_scancode.sv - directed and randomized bench for ps2_scancode against a byte-level model
module tb_ps2_scancode;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2;
  logic        error;

  always #5 clock = ~clock;

  ps2_scancode #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2      (ps2),
    .error    (error)
  );

  int n_vec = 0;
  int n_fail = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int got_err = 0, exp_err = 0;
  int strobe_long = 0, hold_viol = 0;
  logic prev_strobe = 1'b0;
  logic [9:0] last_code = '0;
  bit m_ext = 0, m_brk = 0;
  int m_skip = 0;

  always @(negedge clock) begin
    if (reset) begin
      prev_strobe = 1'b0;
      last_code   = '0;
    end else begin
      if (ps2[10]) begin
        got_q.push_back(ps2[9:0]);
        if (prev_strobe) strobe_long++;
        last_code = ps2[9:0];
      end else if (ps2[9:0] !== last_code) begin
        hold_viol++;
      end
      if (error) got_err++;
      prev_strobe = ps2[10];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 10'h3FF;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if ((b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) ||
                 (m_ext && (b == 8'h12 || b == 8'h59))) begin
      m_ext = 0; m_brk = 0;
    end else begin
      exp_q.push_back({m_brk, m_ext, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_bit(input bit b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(4 * HALF);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  task automatic check_step(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk({tag, " event"}, got_at(i), exp_q[i]);
    chk({tag, " error"}, got_err, exp_err);
    got_q.delete();
    exp_q.delete();
    got_err = 0;
    exp_err = 0;
  endtask

  initial begin
    logic [7:0] pre [6];
    logic [7:0] b;
    bit bad;
    pre = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA};

    wait_cyc(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset ps2", ps2, 11'h000);
    chk("reset error", error, 1'b0);
    wait_cyc(20);

    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    chk("make", got_at(0), 10'h01C);
    chk("break", got_at(1), 10'h21C);
    check_step("make_break");

    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    chk("ext make", got_at(0), 10'h175);
    chk("ext break", got_at(1), 10'h375);
    check_step("extended");

    send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
    send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
    send_frame(8'hE0); send_frame(8'h12);
    check_step("pause_fakeshift");
    send_frame(8'h16);
    chk("after pause", got_at(0), 10'h016);
    check_step("after_pause");

    send_frame(8'hF0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C);
    chk("after parity err", got_at(0), 10'h01C);
    check_step("parity");
    send_frame(8'hF0);
    send_frame(8'h1C, 0, 1);
    send_frame(8'h1C);
    chk("after stop err", got_at(0), 10'h01C);
    check_step("stop");

    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT + 50);
    exp_err++;
    check_step("timeout");
    send_frame(8'h2D);
    chk("after timeout", got_at(0), 10'h02D);
    check_step("post_timeout");

    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FILTER - 3);
    ps2_clk = 1'b1;
    wait_cyc(5);
    ps2_data = 1'b1;
    wait_cyc(50);
    send_frame(8'h3A);
    chk("after glitch", got_at(0), 10'h03A);
    check_step("glitch");

    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    ps2_data = 1'b1;
    m_ext = 0; m_brk = 0; m_skip = 0;
    @(negedge clock);
    chk("midreset ps2", ps2, 11'h000);
    chk("midreset error", error, 1'b0);
    wait_cyc(60);
    send_frame(8'h29);
    chk("after reset", got_at(0), 10'h029);
    check_step("mid_reset");

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 3) b = pre[$urandom_range(0, 5)];
      else b = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad, 0);
    end
    check_step("random");

    chk("strobe width", strobe_long, 0);
    chk("code hold", hold_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
